host_command_issuer: RTL

Host-side transmitter and collector for the polynomial evaluation accelerator. It encodes one host request (STP, EVP, EVB or RST) into a 16-bit command word and writes it into the accelerator's input command FIFO. It then streams the request's operand words into the input data FIFO, drains the matching result/status pairs from the output FIFOs, and returns them to the host one pair at a time.

---
 rtl/host_command_issuer_if.sv | 32 +++
 rtl/host_command_issuer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/host_command_issuer_if.sv
// Host-side bundle for host_command_issuer: request handshake, operand
// stream and response strobe.
//   master : host / stimulus side (drives request and operand words)
//   slave  : host_command_issuer (accepts requests, returns responses)
interface host_command_issuer_if #(
   parameter int word_size = 16
) ();
   logic                 req_valid;
   logic                 req_ready;
   logic [7:0]           req_instr;
   logic [2:0]           req_arg1;
   logic [4:0]           req_arg2;

   logic                 hd_valid;
   logic                 hd_ready;
   logic [word_size-1:0] hd_data;

   logic                 rsp_valid;
   logic [word_size-1:0] rsp_result;
   logic [word_size-1:0] rsp_status;
   logic                 rsp_last;

   modport master (
      output req_valid, req_instr, req_arg1, req_arg2, hd_valid, hd_data,
      input  req_ready, hd_ready, rsp_valid, rsp_result, rsp_status, rsp_last
   );

   modport slave (
      input  req_valid, req_instr, req_arg1, req_arg2, hd_valid, hd_data,
      output req_ready, hd_ready, rsp_valid, rsp_result, rsp_status, rsp_last
   );
endinterface

// File: rtl/host_command_issuer.sv
// host_command_issuer: encodes one host request into a command word for the
// polynomial accelerator, streams its operand words into the data FIFO, then
// drains result/status pairs and hands them back one response at a time.
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   host              host request / operand / response bundle (slave)
//   wr_fifo_command, command_out, full_fifo_command   command FIFO write side
//   wr_fifo_data, data_out, full_fifo_data            data FIFO write side
//   empty_fifo_result/status, rd_fifo_result/status,
//   result_in, status_in                              output FIFO read side
//   busy              high whenever not IDLE
//
// state    | meaning
// IDLE     | ready for a host request
// CMD      | writing the latched command word (stalls on full)
// DATA     | forwarding host operand words to the data FIFO
// WAIT_RSP | waiting for both output FIFOs to hold an entry
// READ     | one-cycle read strobe to both output FIFOs
// CAPTURE  | sampling result_in / status_in
// RESP     | one-cycle response strobe to the host
module host_command_issuer #(
   parameter int word_size = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   host_command_issuer_if.slave host,
   output logic                 wr_fifo_command,
   output logic [word_size-1:0] command_out,
   input  logic                 full_fifo_command,
   output logic                 wr_fifo_data,
   output logic [word_size-1:0] data_out,
   input  logic                 full_fifo_data,
   input  logic                 empty_fifo_result,
   input  logic                 empty_fifo_status,
   output logic                 rd_fifo_result,
   output logic                 rd_fifo_status,
   input  logic [word_size-1:0] result_in,
   input  logic [word_size-1:0] status_in,
   output logic                 busy
);
   localparam logic [7:0] op_stp = 8'h01;
   localparam logic [7:0] op_evp = 8'h02;
   localparam logic [7:0] op_evb = 8'h03;
   localparam logic [7:0] op_rst = 8'h05;

   typedef enum logic [2:0] {
      IDLE, CMD, DATA, WAIT_RSP, READ, CAPTURE, RESP
   } state_t;

   state_t               state;
   logic [5:0]           data_cnt;
   logic [5:0]           rsp_cnt;
   logic [word_size-1:0] rsp_result_q;
   logic [word_size-1:0] rsp_status_q;

   logic [5:0]           d_load;
   logic [5:0]           r_load;
   logic                 legal;

   always_comb begin
      d_load = 6'd0;
      r_load = 6'd0;
      legal  = 1'b1;
      case (host.req_instr)
         op_stp: begin
            d_load = {1'b0, host.req_arg2} + 6'd1;
            r_load = 6'd1;
         end
         op_evp: begin
            d_load = 6'd1;
            r_load = 6'd1;
         end
         op_evb: begin
            d_load = {1'b0, host.req_arg2};
            r_load = {1'b0, host.req_arg2};
         end
         op_rst: ;
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         data_cnt     <= '0;
         rsp_cnt      <= '0;
         command_out  <= '0;
         rsp_result_q <= '0;
         rsp_status_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (host.req_valid) begin
                  command_out <= {host.req_instr, host.req_arg1, host.req_arg2};
                  data_cnt    <= d_load;
                  rsp_cnt     <= r_load;
                  if (legal) begin
                     state <= CMD;
                  end else begin
                     // Illegal opcode answers locally with a fixed error pair.
                     rsp_cnt      <= 6'd1;
                     rsp_result_q <= '0;
                     rsp_status_q <= '1;
                     state        <= RESP;
                  end
               end
            end
            CMD: begin
               if (!full_fifo_command) begin
                  if (data_cnt != 6'd0)     state <= DATA;
                  else if (rsp_cnt != 6'd0) state <= WAIT_RSP;
                  else                      state <= IDLE;
               end
            end
            DATA: begin
               if (wr_fifo_data) begin
                  data_cnt <= data_cnt - 6'd1;
                  if (data_cnt == 6'd1)
                     state <= (rsp_cnt != 6'd0) ? WAIT_RSP : IDLE;
               end
            end
            WAIT_RSP: begin
               if (!empty_fifo_result && !empty_fifo_status) state <= READ;
            end
            READ: state <= CAPTURE;
            CAPTURE: begin
               rsp_result_q <= result_in;
               rsp_status_q <= status_in;
               state        <= RESP;
            end
            RESP: begin
               rsp_cnt <= rsp_cnt - 6'd1;
               state   <= (rsp_cnt == 6'd1) ? IDLE : WAIT_RSP;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are decoded from the state register; only the FIFO-full
   // qualifiers and the operand handshake pass through combinationally.
   assign host.req_ready  = (state == IDLE);
   assign busy            = (state != IDLE);
   assign wr_fifo_command = (state == CMD) && !full_fifo_command;
   assign host.hd_ready   = (state == DATA) && !full_fifo_data;
   assign wr_fifo_data    = host.hd_ready && host.hd_valid;
   assign data_out        = host.hd_data;
   assign rd_fifo_result  = (state == READ);
   assign rd_fifo_status  = (state == READ);
   assign host.rsp_valid  = (state == RESP);
   assign host.rsp_last   = (state == RESP) && (rsp_cnt == 6'd1);
   assign host.rsp_result = rsp_result_q;
   assign host.rsp_status = rsp_status_q;
endmodule
